// File: rtl/h14tx_encoding_lanes_if.sv
// ---------------------------------------------------------------------------
// h14tx_enc_pkg / h14tx_encoding_lanes_if
//
// Purpose: shared period encoding plus the bundle of signals that runs
// between the period scheduler (master) and the multi-lane encoder (slave).
//
// Signals (Lanes = number of TMDS channels):
//   ctl       [Lanes][2]  per-lane control bits {C1,C0}      master -> slave
//   data      [Lanes][4]  per-lane TERC4 nibble              master -> slave
//   video     [Lanes][8]  per-lane pixel byte                master -> slave
//   period    period_t    current period, shared by lanes    master -> slave
//   err_clr   1           clears the sticky protocol flag    master -> slave
//   symbol    [Lanes][10] encoded symbols, bit 9 MSB         slave -> master
//   proto_err 1           sticky protocol-violation flag     slave -> master
// ---------------------------------------------------------------------------
package h14tx_enc_pkg;
  typedef enum logic [2:0] {
    P_CONTROL      = 3'd0,
    P_VIDEO_PRE    = 3'd1,
    P_VIDEO_GUARD  = 3'd2,
    P_VIDEO_ACTIVE = 3'd3,
    P_DI_PRE       = 3'd4,
    P_DI_GUARD     = 3'd5,
    P_DI_ACTIVE    = 3'd6
  } period_t;
endpackage

interface h14tx_encoding_lanes_if
  import h14tx_enc_pkg::*;
#(
  parameter int Lanes = 3
);
  logic [Lanes-1:0][1:0] ctl;
  logic [Lanes-1:0][3:0] data;
  logic [Lanes-1:0][7:0] video;
  period_t               period;
  logic                  err_clr;
  logic [Lanes-1:0][9:0] symbol;
  logic                  proto_err;

  modport master (
    output ctl, data, video, period, err_clr,
    input  symbol, proto_err
  );

  modport slave (
    input  ctl, data, video, period, err_clr,
    output symbol, proto_err
  );
endinterface

// File: rtl/h14tx_encoding_lanes.sv
// ---------------------------------------------------------------------------
// h14tx_encoding_lanes
//
// Purpose: encodes Lanes HDMI 1.4 TMDS channels in one block. Each lane picks
// a control, TERC4, guard or 8b/10b video symbol according to the shared
// period, and the result is delayed through a Stages-deep register pipeline
// (latency = Stages cycles). Each lane keeps its own running disparity.
//
// Ports:
//   clk     pixel clock
//   rst     asynchronous active-high reset
//   enc_if  h14tx_encoding_lanes_if.slave (ctl/data/video/period/err_clr in,
//           symbol/proto_err out)
//
// Optional feature: define H14TX_ENC_PROTOCOL_CHECK_EN to build the period
// sequence checker that drives proto_err. Without it proto_err is 0 and
// err_clr is ignored.
// ---------------------------------------------------------------------------
module h14tx_encoding_lanes
  import h14tx_enc_pkg::*;
#(
  parameter int Lanes  = 3,
  parameter int Stages = 1
) (
  input logic                    clk,
  input logic                    rst,
  h14tx_encoding_lanes_if.slave  enc_if
);

  localparam logic [9:0] CTRL00 = 10'h354;

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = 10'h354;
      2'b01:   s = 10'h0AB;
      2'b10:   s = 10'h154;
      default: s = 10'h2AB;
    endcase
    return s;
  endfunction

  function automatic logic [9:0] terc4(input logic [3:0] d);
    logic [9:0] s;
    case (d)
      4'h0: s = 10'h29C;  4'h1: s = 10'h263;  4'h2: s = 10'h2E4;  4'h3: s = 10'h2E2;
      4'h4: s = 10'h171;  4'h5: s = 10'h11E;  4'h6: s = 10'h18E;  4'h7: s = 10'h13C;
      4'h8: s = 10'h2CC;  4'h9: s = 10'h139;  4'hA: s = 10'h19C;  4'hB: s = 10'h2C6;
      4'hC: s = 10'h28E;  4'hD: s = 10'h271;  4'hE: s = 10'h163;  default: s = 10'h2C3;
    endcase
    return s;
  endfunction

  // DVI 8b/10b: returns {symbol[9:0], next disparity[4:0]}.
  function automatic logic [14:0] tmds_encode(input logic [7:0] d,
                                              input logic signed [4:0] cnt);
    logic [8:0]        q_m;
    logic [3:0]        n1d, n1q, n0q;
    logic              use_xnor;
    logic signed [4:0] diff, two_qm8, cnt_n;
    logic [9:0]        q;
    n1d = '0;
    for (int k = 0; k < 8; k++) n1d = n1d + 4'(d[k]);
    use_xnor = (n1d > 4'd4) || (n1d == 4'd4 && !d[0]);
    q_m[0] = d[0];
    for (int k = 1; k < 8; k++)
      q_m[k] = use_xnor ? ~(q_m[k-1] ^ d[k]) : (q_m[k-1] ^ d[k]);
    q_m[8] = ~use_xnor;
    n1q = '0;
    for (int k = 0; k < 8; k++) n1q = n1q + 4'(q_m[k]);
    n0q     = 4'd8 - n1q;
    diff    = $signed({1'b0, n1q}) - $signed({1'b0, n0q});   // N1 - N0
    two_qm8 = q_m[8] ? 5'sd2 : 5'sd0;
    if (cnt == 5'sd0 || n1q == n0q) begin
      q     = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      cnt_n = q_m[8] ? (cnt + diff) : (cnt - diff);
    end else if ((!cnt[4] && n1q > n0q) || (cnt[4] && n0q > n1q)) begin
      // cnt is non-zero here, so the sign bit alone separates >0 from <0
      q     = {1'b1, q_m[8], ~q_m[7:0]};
      cnt_n = cnt + two_qm8 - diff;
    end else begin
      q     = {1'b0, q_m[8], q_m[7:0]};
      cnt_n = cnt - (q_m[8] ? 5'sd0 : 5'sd2) + diff;
    end
    return {q, cnt_n};
  endfunction

  logic [Lanes-1:0][9:0] stage_in;
  logic [Lanes-1:0][9:0] pipe_q [Stages];

  for (genvar gi = 0; gi < Lanes; gi++) begin : g_lane
    logic [14:0]       tmds_res;
    logic [9:0]        sel_sym;
    logic signed [4:0] cnt_q, cnt_d;

    always_comb begin
      tmds_res = tmds_encode(enc_if.video[gi], cnt_q);
      sel_sym  = ctrl_code(enc_if.ctl[gi]);
      case (enc_if.period)
        P_DI_ACTIVE:    sel_sym = terc4(enc_if.data[gi]);
        P_VIDEO_GUARD:  sel_sym = (gi % 2 == 0) ? 10'h2CC : 10'h133;
        P_DI_GUARD:     sel_sym = (gi == 0) ? terc4(enc_if.data[gi]) : 10'h133;
        P_VIDEO_ACTIVE: sel_sym = tmds_res[14:5];
        default:        ;
      endcase
    end

    assign cnt_d        = $signed(tmds_res[4:0]);
    assign stage_in[gi] = sel_sym;

    // Disparity only survives across consecutive VideoActive cycles.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                cnt_q <= '0;
      else if (enc_if.period == P_VIDEO_ACTIVE) cnt_q <= cnt_d;
      else                                    cnt_q <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < Stages; s++) pipe_q[s] <= {Lanes{CTRL00}};
    end else begin
      pipe_q[0] <= stage_in;
      for (int s = 1; s < Stages; s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign enc_if.symbol = pipe_q[Stages-1];

`ifdef H14TX_ENC_PROTOCOL_CHECK_EN
  typedef enum logic [3:0] {
    S_CTRL, S_VPRE, S_VGRD, S_VACT, S_DPRE, S_DLGRD, S_DACT, S_DTGRD, S_RESYNC
  } chk_state_t;

  chk_state_t state_q;
  logic [9:0] len_q;   // cycles spent in the current state
  logic       err_q;
  period_t    p;

  assign p = enc_if.period;

  // err_clr is applied first so that a fault raised in the same cycle,
  // being the later non-blocking write, keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CTRL;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (enc_if.err_clr) err_q <= 1'b0;
      case (state_q)
        S_CTRL:
          if (p == P_CONTROL) ;
          else if (p == P_VIDEO_PRE) begin state_q <= S_VPRE; len_q <= 10'd1; end
          else if (p == P_DI_PRE)    begin state_q <= S_DPRE; len_q <= 10'd1; end
          else begin state_q <= S_RESYNC; len_q <= '0; err_q <= 1'b1; end
        S_VPRE:
          if (p == P_VIDEO_PRE && len_q < 10'd8) len_q <= len_q + 10'd1;
          else if (p == P_VIDEO_GUARD && len_q == 10'd8) begin state_q <= S_VGRD; len_q <= 10'd1; end
          else begin state_q <= S_RESYNC; len_q <= '0; err_q <= 1'b1; end
        S_VGRD:
          if (p == P_VIDEO_GUARD && len_q < 10'd2) len_q <= len_q + 10'd1;
          else if (p == P_VIDEO_ACTIVE && len_q == 10'd2) begin state_q <= S_VACT; len_q <= '0; end
          else begin state_q <= S_RESYNC; len_q <= '0; err_q <= 1'b1; end
        S_VACT:
          if (p == P_VIDEO_ACTIVE) ;
          else if (p == P_CONTROL) state_q <= S_CTRL;
          else begin state_q <= S_RESYNC; len_q <= '0; err_q <= 1'b1; end
        S_DPRE:
          if (p == P_DI_PRE && len_q < 10'd8) len_q <= len_q + 10'd1;
          else if (p == P_DI_GUARD && len_q == 10'd8) begin state_q <= S_DLGRD; len_q <= 10'd1; end
          else begin state_q <= S_RESYNC; len_q <= '0; err_q <= 1'b1; end
        S_DLGRD:
          if (p == P_DI_GUARD && len_q < 10'd2) len_q <= len_q + 10'd1;
          else if (p == P_DI_ACTIVE && len_q == 10'd2) begin state_q <= S_DACT; len_q <= 10'd1; end
          else begin state_q <= S_RESYNC; len_q <= '0; err_q <= 1'b1; end
        S_DACT:
          // len_q >= 1 here, so a zero low field means a non-zero multiple of 32
          if (p == P_DI_ACTIVE && len_q < 10'd576) len_q <= len_q + 10'd1;
          else if (p == P_DI_GUARD && len_q[4:0] == 5'd0) begin state_q <= S_DTGRD; len_q <= 10'd1; end
          else begin state_q <= S_RESYNC; len_q <= '0; err_q <= 1'b1; end
        S_DTGRD:
          if (p == P_DI_GUARD && len_q < 10'd2) len_q <= len_q + 10'd1;
          else if (p == P_CONTROL && len_q == 10'd2) begin state_q <= S_CTRL; len_q <= '0; end
          else begin state_q <= S_RESYNC; len_q <= '0; err_q <= 1'b1; end
        S_RESYNC:
          if (p == P_CONTROL) state_q <= S_CTRL;
        default: begin state_q <= S_RESYNC; len_q <= '0; end
      endcase
    end
  end

  assign enc_if.proto_err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr   = enc_if.err_clr;
  assign enc_if.proto_err = 1'b0;
`endif

endmodule

// File: doc/h14tx_encoding_lanes.md
# h14tx_encoding_lanes

Multi-lane symbol encoder for the HDMI 1.4 transmitter, sitting between the period scheduler and the serialisers. It replaces the per-channel encoding top and encodes `Lanes` channels in one block. Each lane's output is selected by `period` from control, TERC4, guard and TMDS codes, then registered through a `Stages`-deep pipeline. The block owns each lane's TMDS running-disparity state and can optionally police the period sequence for protocol violations.

## Interface
- `Lanes`, 3: number of TMDS data channels; lane index `i` is HDMI channel `i`, and guard codes follow it.
- `Stages`, 1: output register depth, ≥1; equals the latency in cycles.
- `clk` input 1: pixel clock.
- `rst` input 1: asynchronous, active-high reset.
- `ctl` input `[Lanes][2]`: per-lane control bits {C1,C0}.
- `data` input `[Lanes][4]`: per-lane TERC4 nibble.
- `video` input `[Lanes][8]`: per-lane pixel byte.
- `period` input `period_t`: current period, shared by all lanes.
- `err_clr` input 1: clears `proto_err`.
- `symbol` output `[Lanes][10]`: encoded symbols, bit 9 MSB, registered.
- `proto_err` output 1: sticky protocol-violation flag, registered.

## Operation
- **Control, VideoPreamble, DataIslandPreamble:** `ctl` encoded as follows.
  - 00 → 0x354
  - 01 → 0x0AB
  - 10 → 0x154
  - 11 → 0x2AB
- **DataIslandActive:** standard HDMI TERC4 table applied to `data`.
- **VideoGuard:**
  - even lanes → 0x2CC
  - odd lanes → 0x133
- **DataIslandGuard:**
  - lane 0 → TERC4 of `data`
  - other lanes → 0x133
- **VideoActive:** DVI 8b/10b TMDS encoding.
  - Stage 1 is XOR/XNOR minimisation (XNOR when N1>4, or when N1==4 and bit0==0).
  - Stage 2 is DC balancing against the per-lane signed 5-bit disparity `cnt`.
  - Disparity update follows DVI: `cnt += N0-N1` or `N1-N0`, ±`2*q_m[8]` on inversion paths.
  - Arithmetic is two's complement and is never saturated.
- **Disparity reset:** each lane's `cnt` is forced to 0 on every cycle where `period != VideoActive`.
  - The first active pixel after a guard therefore always starts from `cnt == 0`.
- **Pipeline:** the selected symbol enters stage 1, and `symbol` is the last stage. Stages have no enables and shift every cycle.
- **Protocol checker** (when compiled in), FSM states:
  - CTRL, VPRE, VGRD, VACT
  - DPRE, DLGRD, DACT, DTGRD
  - RESYNC
- **Checker transitions:**
  - CTRL → VPRE or DPRE on the first preamble cycle.
  - A preamble must last exactly 8 cycles, then be followed by its own guard type.
  - VGRD lasts exactly 2 cycles, then VideoActive follows.
  - VACT lasts ≥1 cycle, then Control follows.
  - DLGRD lasts exactly 2 cycles, then DataIslandActive follows.
  - DACT length must be a multiple of 32 in 32..576; an internal 10-bit counter tracks it.
  - DTGRD lasts exactly 2 cycles, then Control follows.
- **Checker errors:**
  - Any other `period` value, or a wrong length, sets the error flag and sends the FSM to RESYNC.
  - RESYNC exits to CTRL on the first Control cycle without flagging again.
  - If a new error and `err_clr` arrive in the same cycle, the error wins and the flag stays set.
- **Signal sourcing:** the checker only observes `period`; it never alters `symbol`. `proto_err` is driven straight from the flag register.

## Timing
- Latency is `Stages` cycles from `period`/input sampling to `symbol`, identical for all lanes and all period types.
- `cnt` updates at the clock edge of the VideoActive cycle that consumed the pixel.
- The checker FSM, counters and flag all update on the same edge that samples `period`.
- `proto_err` rises 1 cycle after the offending `period` cycle.
- `err_clr` takes effect 1 cycle after it is asserted.
- **Reset values:**
  - every pipeline stage = 0x354 on all lanes
  - all `cnt` = 0
  - FSM = CTRL
  - length counters = 0
  - `proto_err` = 0
- Reset may assert in mid-frame; it takes effect immediately and asynchronously, and release is synchronous to `clk`.
- After reset is released, the first emitted period is accepted as if it followed Control.

## Configuration
- `H14TX_ENC_PROTOCOL_CHECK_EN` defined:
  - the checker FSM, length counters and flag are built
  - `proto_err` behaves as described above
- Not defined:
  - no checker logic is built
  - `proto_err` is tied to 0
  - `err_clr` is ignored
  - encoding and latency are unchanged

## Test plan
- Reset, then Control with `ctl`=00/01/10/11 on lane 0 → `symbol` is 0x354, 0x0AB, 0x154, 0x2AB, each `Stages` cycles later.
- Legal sequence: Control, 8×VideoPreamble, 2×VideoGuard, video 0x00 ×2 on all lanes.
  - Guard cycles → lane0 0x2CC, lane1 0x133, lane2 0x2CC.
  - Pixels → 0x100, then 0x3FF (`cnt` goes 0 → −8 → +2).
  - `proto_err` stays 0.
- Data island: 8×DataIslandPreamble, 2×DataIslandGuard with lane0 `data`=0x0, 32×DataIslandActive, 2×DataIslandGuard.
  - Lane0 guard → 0x29C.
  - Lanes 1/2 guard → 0x133.
  - `proto_err` stays 0.
- VideoPreamble of only 7 cycles, then VideoGuard → `proto_err`=1 one cycle after the first guard cycle.
  - `err_clr` with no new error → 0 one cycle later.
- DataIslandActive of 33 cycles → `proto_err`=1; a simultaneous `err_clr` keeps it at 1.
- `rst` pulsed mid-VideoActive → all `symbol` = 0x354 immediately and `cnt` = 0.
  - After release, the next pixel 0x00 following a guard encodes to 0x100.
